// File: rtl/pmem_sram_responder.sv
// ---------------------------------------------------------------------------
// pmem_sram_responder
// Responder end of the pmem outport protocol, terminating initiator requests
// into a single-port synchronous SRAM with one cycle of read latency.
// Supports single-beat writes and incrementing read bursts of len+1 words at
// one beat per cycle. Requests outside the address window get error beats
// and never touch the SRAM.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   inport_wr_i           byte write strobes (non-zero = write request)
//   inport_rd_i           read request (ignored when a write is present)
//   inport_len_i          read burst length minus one
//   inport_addr_i         byte address, bits [1:0] ignored
//   inport_write_data_i   write data
//   inport_accept_o       request taken this cycle (combinational)
//   inport_ack_o          one response beat
//   inport_error_o        response beat is an error
//   inport_read_data_o    read beat data, zero unless a good read beat
//   sram_en_o/wr_o/addr_o/wdata_o  SRAM access (combinational)
//   sram_rdata_i          SRAM read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module pmem_sram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned SRAM_AW   = 14
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [3:0]         inport_wr_i,
  input  logic               inport_rd_i,
  input  logic [7:0]         inport_len_i,
  input  logic [31:0]        inport_addr_i,
  input  logic [31:0]        inport_write_data_i,
  output logic               inport_accept_o,
  output logic               inport_ack_o,
  output logic               inport_error_o,
  output logic [31:0]        inport_read_data_o,
  output logic               sram_en_o,
  output logic [3:0]         sram_wr_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_wdata_o,
  input  logic [31:0]        sram_rdata_i
);

  localparam int unsigned WIN_LSB = SRAM_AW + 2;
  localparam int unsigned LEN_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_RD_ERR   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               ready_q;
  logic [SRAM_AW-1:0] idx_q, idx_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               rdv_q, rdv_d;

  logic               wr_req_c;
  logic               req_c;
  logic               in_range_c;
  logic [SRAM_AW-1:0] req_idx_c;
  logic               accept_c;
  logic               hs_c;

  logic               sram_en_c;
  logic [3:0]         sram_wr_c;
  logic [SRAM_AW-1:0] sram_addr_c;
  logic [31:0]        sram_wdata_c;

  // Byte-offset bits carry no meaning for word accesses.
  logic               unused_addr_lsb_c;
  assign unused_addr_lsb_c = ^inport_addr_i[1:0];

  // Request decode; a write takes priority over a simultaneous read.
  assign wr_req_c   = |inport_wr_i;
  assign req_c      = wr_req_c | inport_rd_i;
  assign in_range_c = (inport_addr_i >> WIN_LSB) == (BASE_ADDR >> WIN_LSB);
  assign req_idx_c  = inport_addr_i[WIN_LSB-1:2];
  assign accept_c   = ready_q & (state_q == ST_IDLE);
  assign hs_c       = req_c & accept_c;

  // Next-state, SRAM access and response-beat generation.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rem_d        = rem_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    rdv_d        = 1'b0;
    sram_en_c    = 1'b0;
    sram_wr_c    = 4'h0;
    sram_addr_c  = idx_q;
    sram_wdata_c = 32'h0;

    unique case (state_q)
      ST_IDLE: begin
        if (hs_c) begin
          ack_d = 1'b1;
          err_d = ~in_range_c;
          if (wr_req_c) begin
            if (in_range_c) begin
              sram_en_c    = 1'b1;
              sram_wr_c    = inport_wr_i;
              sram_addr_c  = req_idx_c;
              sram_wdata_c = inport_write_data_i;
            end
          end else begin
            rdv_d = in_range_c;
            if (in_range_c) begin
              sram_en_c   = 1'b1;
              sram_addr_c = req_idx_c;
            end
            // Beat 0 already issued; the rest run out of the burst states.
            if (inport_len_i != '0) begin
              state_d = in_range_c ? ST_RD_BURST : ST_RD_ERR;
              idx_d   = req_idx_c + SRAM_AW'(1);
              rem_d   = inport_len_i;
            end
          end
        end
      end

      ST_RD_BURST, ST_RD_ERR: begin
        ack_d = 1'b1;
        if (state_q == ST_RD_BURST) begin
          rdv_d       = 1'b1;
          sram_en_c   = 1'b1;
          sram_addr_c = idx_q;
        end else begin
          err_d = 1'b1;
        end
        // Index wraps naturally at the top of the window.
        idx_d = idx_q + SRAM_AW'(1);
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      idx_q   <= '0;
      rem_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdv_q   <= rdv_d;
    end
  end

  assign inport_accept_o    = accept_c;
  assign inport_ack_o       = ack_q;
  assign inport_error_o     = err_q;
  // SRAM data is passed straight through on good read beats only.
  assign inport_read_data_o = rdv_q ? sram_rdata_i : 32'h0;

  assign sram_en_o    = sram_en_c;
  assign sram_wr_o    = sram_wr_c;
  assign sram_addr_o  = sram_addr_c;
  assign sram_wdata_o = sram_wdata_c;

endmodule

// File: tb/tb_pmem_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_pmem_sram_responder
// Drives directed and random pmem requests into the responder backed by a
// behavioural SRAM. A transaction-level model schedules, at each accepted
// request, the SRAM accesses and response beats it must produce in future
// cycles; every cycle the DUT outputs are compared against that schedule.
// ---------------------------------------------------------------------------
module tb_pmem_sram_responder;

  localparam int unsigned AW   = 14;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          NW   = 1 << AW;
  localparam int          RING = 1024;

  logic          clk;
  logic          rst_n;
  logic [3:0]    inport_wr;
  logic          inport_rd;
  logic [7:0]    inport_len;
  logic [31:0]   inport_addr;
  logic [31:0]   inport_wdata;
  logic          accept;
  logic          ack;
  logic          err;
  logic [31:0]   rdata;
  logic          sram_en;
  logic [3:0]    sram_wr;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  pmem_sram_responder #(.BASE_ADDR(BASE), .SRAM_AW(AW)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .inport_wr_i         (inport_wr),
    .inport_rd_i         (inport_rd),
    .inport_len_i        (inport_len),
    .inport_addr_i       (inport_addr),
    .inport_write_data_i (inport_wdata),
    .inport_accept_o     (accept),
    .inport_ack_o        (ack),
    .inport_error_o      (err),
    .inport_read_data_o  (rdata),
    .sram_en_o           (sram_en),
    .sram_wr_o           (sram_wr),
    .sram_addr_o         (sram_addr),
    .sram_wdata_o        (sram_wdata),
    .sram_rdata_i        (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM seen by the DUT.
  logic [31:0] mem [NW];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wr != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wr[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  int n_pass;
  int n_total;
  int cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model state.
  logic [31:0]   shadow [NW];
  bit            m_rdy;
  int            busy;
  bit            e_en  [RING];
  logic [3:0]    e_wr  [RING];
  logic [AW-1:0] e_addr[RING];
  logic [31:0]   e_wd  [RING];
  bit            e_ack [RING];
  bit            e_err [RING];
  logic [31:0]   e_rd  [RING];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_rdy <= 1'b0;
    else        m_rdy <= 1'b1;
  end

  // Schedule responses at each handshake and compare the current cycle.
  always @(negedge clk) begin
    int s;
    int sk;
    int idx;
    int a;
    bit ea;
    bit hs;
    bit inr;
    s = cyc % RING;
    if (!rst_n) begin
      for (int i = 0; i < RING; i++) begin
        e_en[i] = 0; e_wr[i] = 0; e_addr[i] = 0; e_wd[i] = 0;
        e_ack[i] = 0; e_err[i] = 0; e_rd[i] = 0;
      end
      busy = 0;
      chk("rst_accept", 32'(accept), 32'd0);
      chk("rst_ack",    32'(ack),    32'd0);
      chk("rst_en",     32'(sram_en), 32'd0);
      chk("rst_rdata",  rdata,       32'd0);
    end else begin
      ea = m_rdy && (busy == 0);
      chk("accept", 32'(accept), 32'(ea));
      hs = ea && ((inport_wr != 4'h0) || inport_rd);
      if (hs) begin
        inr = (inport_addr >> (AW + 2)) == (BASE >> (AW + 2));
        idx = int'(inport_addr[AW+1:2]);
        if (inport_wr != 4'h0) begin
          if (inr) begin
            e_en[s] = 1; e_wr[s] = inport_wr; e_addr[s] = AW'(idx); e_wd[s] = inport_wdata;
            for (int b = 0; b < 4; b++)
              if (inport_wr[b]) shadow[idx][8*b +: 8] = inport_wdata[8*b +: 8];
          end
          sk = (cyc + 1) % RING;
          e_ack[sk] = 1; e_err[sk] = !inr; e_rd[sk] = 32'h0;
        end else begin
          for (int k = 0; k <= int'(inport_len); k++) begin
            a  = (idx + k) % NW;
            sk = (cyc + k) % RING;
            if (inr) begin
              e_en[sk] = 1; e_wr[sk] = 4'h0; e_addr[sk] = AW'(a);
            end
            sk = (cyc + k + 1) % RING;
            e_ack[sk] = 1; e_err[sk] = !inr; e_rd[sk] = inr ? shadow[a] : 32'h0;
          end
          busy = int'(inport_len);
        end
      end else if (busy > 0) begin
        busy--;
      end
      chk("sram_en", 32'(sram_en), 32'(e_en[s]));
      chk("sram_wr", 32'(sram_wr), 32'(e_wr[s]));
      if (e_en[s]) chk("sram_addr", 32'(sram_addr), 32'(e_addr[s]));
      if (e_en[s] && e_wr[s] != 4'h0) chk("sram_wdata", sram_wdata, e_wd[s]);
      chk("ack",       32'(ack), 32'(e_ack[s]));
      chk("error",     32'(err), 32'(e_err[s]));
      chk("read_data", rdata,    e_rd[s]);
      e_en[s] = 0; e_wr[s] = 0; e_addr[s] = 0; e_wd[s] = 0;
      e_ack[s] = 0; e_err[s] = 0; e_rd[s] = 0;
    end
    cyc++;
  end

  task automatic idle();
    inport_wr = 4'h0; inport_rd = 1'b0; inport_len = 8'h0;
    inport_addr = 32'h0; inport_wdata = 32'h0;
  endtask

  // Present a request until accepted; returns 1 ns after the handshake edge.
  task automatic do_req(input logic [3:0] w, input logic r, input logic [7:0] l,
                        input logic [31:0] a, input logic [31:0] d);
    int n;
    inport_wr = w; inport_rd = r; inport_len = l; inport_addr = a; inport_wdata = d;
    n = 0;
    @(negedge clk);
    while (!accept) begin
      n++;
      if (n > 600) begin
        n_total++;
        $display("FAIL req_timeout: accept never rose for addr 0x%08h", a);
        idle();
        return;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    idle();
  endtask

  function automatic logic [31:0] rand_addr(input bit in_win);
    logic [31:0] a;
    a = $urandom;
    if (in_win) a = BASE | (a & 32'(NW * 4 - 1));
    else if ((a >> (AW + 2)) == (BASE >> (AW + 2))) a = a ^ 32'h8000_0000;
    return a;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_pass = 0; n_total = 0; cyc = 0; busy = 0;
    for (int i = 0; i < NW; i++) begin
      mem[i] = $urandom;
      shadow[i] = mem[i];
    end
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); chk("acc_release0", 32'(accept), 32'd0);
    @(negedge clk); chk("acc_release1", 32'(accept), 32'd1);
    @(posedge clk); #1;

    // Full-word write, checked by hand.
    inport_wr = 4'hF; inport_addr = 32'h10; inport_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("lit_wr_en",   32'(sram_en),   32'd1);
    chk("lit_wr_strb", 32'(sram_wr),   32'hF);
    chk("lit_wr_addr", 32'(sram_addr), 32'd4);
    @(posedge clk); #1; idle();
    @(negedge clk);
    chk("lit_wr_ack", 32'(ack), 32'd1);
    chk("lit_wr_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // Byte write merge then single read.
    do_req(4'b0010, 1'b0, 8'd0, 32'h10, 32'h0000_AB00);
    do_req(4'h0, 1'b1, 8'd0, 32'h10, 32'h0);
    @(negedge clk);
    chk("lit_merge_ack",  32'(ack), 32'd1);
    chk("lit_merge_data", rdata, 32'hDEAD_ABEF);
    @(posedge clk); #1;

    // Burst of 8 over freshly written words.
    for (int k = 0; k < 8; k++) do_req(4'hF, 1'b0, 8'd0, 32'h20 + 32'(4 * k), 32'(k));
    do_req(4'h0, 1'b1, 8'd7, 32'h20, 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("lit_burst_ack",    32'(ack), 32'd1);
      chk("lit_burst_data",   rdata, 32'(k));
      chk("lit_burst_accept", 32'(accept), 32'(k == 7));
    end
    @(posedge clk); #1;

    // Burst wrapping from the last word to index 0.
    do_req(4'hF, 1'b0, 8'd0, 32'hFFFC, 32'h1111_2222);
    do_req(4'hF, 1'b0, 8'd0, 32'h0000, 32'h3333_4444);
    do_req(4'h0, 1'b1, 8'd1, 32'hFFFC, 32'h0);
    @(negedge clk); chk("lit_wrap_b0", rdata, 32'h1111_2222);
    @(negedge clk); chk("lit_wrap_b1", rdata, 32'h3333_4444);
    @(posedge clk); #1;

    // Out-of-window read burst and write.
    do_req(4'h0, 1'b1, 8'd3, 32'h8000_0000, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lit_oor_err",  32'(err), 32'd1);
      chk("lit_oor_data", rdata, 32'd0);
    end
    @(posedge clk); #1;
    do_req(4'hF, 1'b0, 8'd0, 32'h8000_0004, 32'h1234_5678);
    @(negedge clk); chk("lit_oor_wr_err", 32'(err), 32'd1);
    @(posedge clk); #1;

    // Back-to-back single reads.
    for (int k = 0; k < 4; k++) do_req(4'h0, 1'b1, 8'd0, 32'(4 * k), 32'h0);
    repeat (2) @(posedge clk); #1;

    // Read and write together: the write wins.
    do_req(4'hF, 1'b1, 8'd5, 32'h40, 32'hCAFE_F00D);
    do_req(4'h0, 1'b1, 8'd0, 32'h40, 32'h0);
    @(negedge clk); chk("lit_rdwr_data", rdata, 32'hCAFE_F00D);
    @(posedge clk); #1;

    // Reset in the middle of a burst.
    do_req(4'h0, 1'b1, 8'd7, 32'h20, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("lit_midrst_ack", 32'(ack), 32'd0);
    chk("lit_midrst_en",  32'(sram_en), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); chk("lit_midrst_acc0", 32'(accept), 32'd0);
    @(negedge clk); chk("lit_midrst_acc1", 32'(accept), 32'd1);
    @(posedge clk); #1;

    // Longest burst.
    do_req(4'h0, 1'b1, 8'd255, 32'h100, 32'h0);

    // Random mix of writes, reads, bursts and out-of-window requests.
    for (int t = 0; t < 300; t++) begin
      int kind;
      int lr;
      logic [7:0] l;
      logic [31:0] a;
      kind = int'($urandom_range(0, 9));
      a = rand_addr($urandom_range(0, 7) != 0);
      lr = int'($urandom_range(0, 9));
      l = (lr < 6) ? 8'd0 : (lr < 9) ? 8'($urandom_range(1, 15)) : 8'($urandom_range(16, 64));
      if (kind < 4)
        do_req(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), l, a, $urandom);
      else
        do_req(4'h0, 1'b1, l, a, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    repeat (80) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
